// File: rtl/bcd_scan_display_if.sv
// -----------------------------------------------------------------------------
// bcd_scan_display_if
//
// Bundles the control inputs and display/count outputs of bcd_scan_display.
// Clock and reset stay plain ports on the module.
//
// Signals:
//   enable  1        1 = counter advances on count ticks, 0 = frozen
//   up      1        1 = count up, 0 = count down
//   clear   1        synchronous clear of counter and count prescaler
//   seg     7        active-low segments, bit6 = a ... bit0 = g
//   Anode   8        active-low one-hot digit select, bit k = digit k
//   wrap    1        one-cycle pulse when the counter wraps
//   value   4*DIGITS current BCD count, digit k in bits [4k+3:4k]
//
// Modports:
//   master  drives enable/up/clear, observes the outputs
//   slave   the counter/display block itself
// -----------------------------------------------------------------------------
interface bcd_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  up;
  logic                  clear;
  logic [6:0]            seg;
  logic [7:0]            Anode;
  logic                  wrap;
  logic [4*DIGITS-1:0]   value;

  modport master (
    output enable, up, clear,
    input  seg, Anode, wrap, value
  );

  modport slave (
    input  enable, up, clear,
    output seg, Anode, wrap, value
  );
endinterface

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//
// N-digit BCD up/down event counter driving a time-multiplexed, common-anode
// seven-segment display. The count is held natively in BCD, so no
// binary-to-BCD conversion is needed on the display path.
//
// Parameters:
//   CLK_HZ      input clock frequency in Hz
//   COUNT_HZ    count-tick rate; COUNT_DIV = CLK_HZ/COUNT_HZ (>= 2)
//   REFRESH_HZ  full-display refresh rate; SCAN_DIV = CLK_HZ/(REFRESH_HZ*DIGITS)
//               (>= 1)
//   DIGITS      number of displayed digits, 1..8
//
// Ports:
//   Clock   system clock, rising edge
//   reset   asynchronous, active-high
//   bus     bcd_scan_display_if.slave (enable, up, clear, seg, Anode, wrap,
//           value)
//
// Optional feature:
//   Define BCD_SCAN_LZ_BLANK_EN to blank leading zeros: a digit k > 0 shows
//   all segments off when it and every more-significant digit are 0. Digit 0
//   is never blanked. Anode scanning is the same either way.
// -----------------------------------------------------------------------------
module bcd_scan_display #(
  parameter int CLK_HZ     = 100000000,
  parameter int COUNT_HZ   = 1,
  parameter int REFRESH_HZ = 1000,
  parameter int DIGITS     = 4
) (
  input logic              Clock,
  input logic              reset,
  bcd_scan_display_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
  localparam int SCAN_DIV  = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int CW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW        = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW        = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Elaboration-time parameter sanity checks.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_scan_display: DIGITS must be 1..8");
  end
  if (COUNT_DIV < 2) begin : g_bad_count_div
    $error("bcd_scan_display: CLK_HZ/COUNT_HZ must be >= 2");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("bcd_scan_display: CLK_HZ/(REFRESH_HZ*DIGITS) must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Segment decode, active-low, bit6 = a ... bit0 = g
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]            count_pre;
  logic [SW-1:0]            scan_pre;
  logic [IW-1:0]            scan_idx;
  logic [DIGITS-1:0][3:0]   digits_q;
  logic                     wrap_q;
  logic [6:0]               seg_q;
  logic [7:0]               anode_q;

  // Count tick: prescaler terminal cycle. The prescaler only moves while
  // enable is high, so a tick is only ever acted on with enable = 1.
  logic tick;
  assign tick = (count_pre == COUNT_LAST);

  // ---------------------------------------------------------------------------
  // Next BCD count: ripple a carry (up) or borrow (down) from digit 0.
  // A carry/borrow left over past the top digit means the count wrapped.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] digits_nxt;
  logic                   carry;

  always_comb begin
    // NOTE: every variable written here gets a default first; without it a
    // path that skips the assignment would make synthesis infer a latch.
    digits_nxt = digits_q;
    carry      = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (bus.up) begin
          // >= 9 rather than == 9 so an illegal code can never survive.
          if (digits_q[k] >= 4'd9) begin
            digits_nxt[k] = 4'd0;
          end else begin
            digits_nxt[k] = digits_q[k] + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if (digits_q[k] == 4'd0) begin
            digits_nxt[k] = 4'd9;
          end else begin
            digits_nxt[k] = digits_q[k] - 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Count prescaler, BCD counter and wrap pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      count_pre <= '0;
      // NOTE: the digit register bank is reset explicitly because its reset
      // value (all zeros) is visible on value and on the display.
      digits_q  <= '0;
      wrap_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wrap_q <= 1'b0;
      if (bus.clear) begin
        // clear wins over a coincident tick.
        count_pre <= '0;
        digits_q  <= '0;
      end else if (bus.enable) begin
        if (tick) begin
          count_pre <= '0;
          digits_q  <= digits_nxt;
          wrap_q    <= carry;
        end else begin
          count_pre <= count_pre + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit index: free-running, ignores enable and clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      scan_pre <= '0;
      scan_idx <= '0;
    end else if (scan_pre == SCAN_LAST) begin
      scan_pre <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_pre <= scan_pre + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blank mask
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] blank;

`ifdef BCD_SCAN_LZ_BLANK_EN
  logic lz_run;

  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    // Walk from the most-significant digit down; digit 0 is never blanked.
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_run   = lz_run & (digits_q[k] == 4'd0);
      blank[k] = lz_run;
    end
  end
`else
  assign blank = '0;
`endif

  // ---------------------------------------------------------------------------
  // Scanned digit select. A compare loop rather than a variable index keeps
  // the select legal for every DIGITS, including 1 and non-powers of two.
  // ---------------------------------------------------------------------------
  logic [3:0] digit_sel;
  logic       blank_sel;

  always_comb begin
    digit_sel = 4'd0;
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IW'(k)) begin
        digit_sel = digits_q[k];
        blank_sel = blank[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: seg and Anode are registered together so the segment data
  // always belongs to the digit whose anode is active.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      seg_q   <= SEG_OFF;
      anode_q <= 8'hFF;
    end else begin
      anode_q <= ~(8'd1 << scan_idx);
      seg_q   <= blank_sel ? SEG_OFF : seg_decode(digit_sel);
    end
  end

  assign bus.seg   = seg_q;
  assign bus.Anode = anode_q;
  assign bus.wrap  = wrap_q;
  assign bus.value = digits_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
//
// Three instances:
//   dut_a  DIGITS=2, COUNT_DIV=10, SCAN_DIV=10 - counting, wrap, enable,
//          clear and reset; every cycle is scored against a decimal model.
//   dut_b  DIGITS=3, SCAN_DIV=2 - anode sequence FE/FD/FB.
//   dut_c  DIGITS=8, COUNT_DIV=2, SCAN_DIV=2 - counted to 305, then the
//          per-digit segment pattern (with or without leading-zero blanking).
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

`ifdef BCD_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic Clock   = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;

  always #5 Clock = ~Clock;

  bcd_scan_display_if #(.DIGITS(2)) bus_a ();
  bcd_scan_display_if #(.DIGITS(3)) bus_b ();
  bcd_scan_display_if #(.DIGITS(8)) bus_c ();

  bcd_scan_display #(.CLK_HZ(100), .COUNT_HZ(10), .REFRESH_HZ(5), .DIGITS(2))
    dut_a (.Clock(Clock), .reset(reset_a), .bus(bus_a));
  bcd_scan_display #(.CLK_HZ(30), .COUNT_HZ(10), .REFRESH_HZ(5), .DIGITS(3))
    dut_b (.Clock(Clock), .reset(reset_b), .bus(bus_b));
  bcd_scan_display #(.CLK_HZ(16), .COUNT_HZ(8), .REFRESH_HZ(1), .DIGITS(8))
    dut_c (.Clock(Clock), .reset(reset_b), .bus(bus_c));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode table, active-low a..g.
  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // Expected segments for digit k of a decimal count val.
  function automatic logic [6:0] exp_seg(input int k, input int val);
    int p = 10 ** k;
    if (LZ && k > 0 && val < p) return 7'b1111111;
    return seg_tbl[(val / p) % 10];
  endfunction

  function automatic logic [7:0] anode_of(input int idx);
    logic [7:0] a = 8'hFF;
    a[idx] = 1'b0;
    return a;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // dut_a scoreboard: predictor pushes at each edge, checker pops 1 later.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] value;
    logic       wrap;
    logic [7:0] anode;
    logic [6:0] seg;
  } exp_t;

  exp_t sb_q [$];

  int         m_pre = 0, m_val = 0, m_spre = 0, m_idx = 0;
  logic       m_wrap = 1'b0;
  logic [7:0] m_anode = 8'hFF;
  logic [6:0] m_seg = 7'h7F;

  always @(posedge Clock) begin
    exp_t        e;
    logic [31:0] bcd;
    if (reset_a) begin
      m_pre = 0; m_val = 0; m_spre = 0; m_idx = 0;
      m_wrap = 1'b0; m_anode = 8'hFF; m_seg = 7'h7F;
    end else begin
      m_anode = anode_of(m_idx);
      m_seg   = exp_seg(m_idx, m_val);
      m_wrap  = 1'b0;
      if (bus_a.clear) begin
        m_val = 0;
        m_pre = 0;
      end else if (bus_a.enable) begin
        if (m_pre == 9) begin
          m_pre  = 0;
          m_wrap = bus_a.up ? (m_val == 99) : (m_val == 0);
          m_val  = bus_a.up ? (m_val + 1) % 100 : (m_val + 99) % 100;
        end else begin
          m_pre++;
        end
      end
      if (m_spre == 9) begin
        m_spre = 0;
        m_idx  = (m_idx + 1) % 2;
      end else begin
        m_spre++;
      end
    end
    bcd     = to_bcd(m_val, 2);
    e.value = bcd[7:0];
    e.wrap  = m_wrap;
    e.anode = m_anode;
    e.seg   = m_seg;
    sb_q.push_back(e);
  end

  always @(posedge Clock) begin
    exp_t e;
    #1;
    check("a_sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("a_value", bus_a.value, e.value);
      check("a_wrap",  bus_a.wrap,  e.wrap);
      check("a_anode", bus_a.Anode, e.anode);
      check("a_seg",   bus_a.seg,   e.seg);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int         idx;
    logic [7:0] an;
    bus_a.enable = 1'b0; bus_a.up = 1'b1; bus_a.clear = 1'b0;
    bus_b.enable = 1'b0; bus_b.up = 1'b1; bus_b.clear = 1'b0;
    bus_c.enable = 1'b0; bus_c.up = 1'b1; bus_c.clear = 1'b0;

    #1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    #1;
    check("rst_seg",   bus_a.seg,   7'h7F);
    check("rst_anode", bus_a.Anode, 8'hFF);
    check("rst_wrap",  bus_a.wrap,  1'b0);
    check("rst_value", bus_a.value, 8'h00);
    check("rst_anode_c", bus_c.Anode, 8'hFF);

    // --- dut_b / dut_c ------------------------------------------------------
    run(2);
    reset_b      = 1'b0;
    bus_c.enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge Clock);
      idx = ((n - 1) / 2) % 3;
      an  = anode_of(idx);
      check("b_anode", bus_b.Anode, an);
      check("b_seg",   bus_b.seg,   exp_seg(idx, 0));
    end
    run(598);
    bus_c.enable = 1'b0;
    check("c_value", bus_c.value, 32'h00000305);
    for (int n = 611; n <= 630; n++) begin
      @(negedge Clock);
      idx = ((n - 1) / 2) % 8;
      an  = anode_of(idx);
      check("c_anode", bus_c.Anode, an);
      check("c_seg",   bus_c.seg,   exp_seg(idx, 305));
    end

    // --- dut_a: count up, hold, resume -------------------------------------
    reset_a      = 1'b0;
    bus_a.enable = 1'b1;
    bus_a.up     = 1'b1;
    run(420);
    check("a_at_42", bus_a.value, 8'h42);
    run(4);
    bus_a.enable = 1'b0;
    run(35);
    check("a_hold_42", bus_a.value, 8'h42);
    bus_a.enable = 1'b1;
    run(5);
    check("a_resume_wait", bus_a.value, 8'h42);
    run(1);
    check("a_resume_tick", bus_a.value, 8'h43);

    // --- wrap up then down --------------------------------------------------
    run(560);
    check("a_at_99", bus_a.value, 8'h99);
    run(9);
    check("a_pre_wrap", bus_a.wrap, 1'b0);
    run(1);
    check("a_wrap_up_val", bus_a.value, 8'h00);
    check("a_wrap_up",     bus_a.wrap,  1'b1);
    run(1);
    check("a_wrap_up_end", bus_a.wrap,  1'b0);
    bus_a.up = 1'b0;
    run(8);
    check("a_pre_down", bus_a.value, 8'h00);
    run(1);
    check("a_wrap_dn_val", bus_a.value, 8'h99);
    check("a_wrap_dn",     bus_a.wrap,  1'b1);
    run(1);
    check("a_wrap_dn_end", bus_a.wrap,  1'b0);

    // --- clear, then clear colliding with a tick at 17 ---------------------
    bus_a.clear = 1'b1;
    run(1);
    bus_a.clear = 1'b0;
    check("a_clear", bus_a.value, 8'h00);
    bus_a.up = 1'b1;
    run(170);
    check("a_at_17", bus_a.value, 8'h17);
    run(9);
    bus_a.clear = 1'b1;
    run(1);
    bus_a.clear = 1'b0;
    check("a_clr_tick_val",  bus_a.value, 8'h00);
    check("a_clr_tick_wrap", bus_a.wrap,  1'b0);
    run(25);

    // --- asynchronous reset mid-scan ---------------------------------------
    run(7);
    #2;
    reset_a = 1'b1;
    #1;
    check("a_async_seg",   bus_a.seg,   7'h7F);
    check("a_async_anode", bus_a.Anode, 8'hFF);
    check("a_async_value", bus_a.value, 8'h00);
    run(2);
    reset_a = 1'b0;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
